// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive slave: oversamples SCK/CS/MOSI on clk, reassembles words into a
// single-entry valid/ready holding register and returns a response word on MISO.
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   sck_s, cs_s, mosi_s, warm;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      warm_q      <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  // Edges are ignored until the pipelines hold real input, so a CS already low at
  // reset release never looks like a falling edge.
  assign warm     = warm_q[SYNC_STAGES];
  assign sck_rise = warm & sck_s & ~sck_dly_q;
  assign sck_fall = warm & ~sck_s & sck_dly_q;
  assign cs_rise  = warm & cs_s & ~cs_dly_q;
  assign cs_fall  = warm & ~cs_s & cs_dly_q;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, byte_word;
  logic              reload_q, reload_d, miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d, byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      reload_q    <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      reload_q    <= reload_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    reload_d    = reload_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    byte_word   = {rx_sr_q[DATA_W-2:0], mosi_s};

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d  = StShift;
          cnt_d    = '0;
          reload_d = 1'b0;
          tx_sr_d  = tx_data;
          miso_d   = tx_data[DATA_W-1];
        end
      end
      StShift: begin
        // CS rise takes priority over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d     = StIdle;
          miso_d      = 1'b0;
          cnt_d       = '0;
          reload_d    = 1'b0;
          frame_err_d = (cnt_q != '0);
        end else if (sck_rise) begin
          rx_sr_d = byte_word;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            cnt_d     = '0;
            byte_done = 1'b1;
            reload_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            tx_sr_d  = tx_data;
            miso_d   = tx_data[DATA_W-1];
            reload_d = 1'b0;
          end else begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[DATA_W-2];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = byte_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign spi_miso  = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bit-banged SPI mode-0 master at clk/8 with a queue-based model of
// expected received words and MISO response words.
module tb_spi_slave_rx;

  logic       clk, rst_n;
  logic       spi_sck, spi_mosi, spi_cs, spi_miso;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, rx_ready, overrun, overrun_clr, frame_err, busy;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_cs     (spi_cs),
    .spi_miso   (spi_miso),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  int         fe_cnt  = 0;
  int         last_lat;
  logic       busy_mid;
  logic [7:0] mo_buf [8];
  logic [7:0] so_buf [8];
  logic [7:0] mi_buf [8];
  logic [7:0] got_q [$];

  // Observe accepted handshakes and frame_err cycles away from the active edge.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rst_n && frame_err) fe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic half();
    repeat (4) tick();
  endtask

  // n words of mo_buf out, so_buf offered as responses; nbits>0 aborts after that many bits.
  task automatic spi_frame(input int n, input int nbits);
    int total;
    total = (nbits > 0) ? nbits : n * 8;
    for (int k = 0; k < n; k++) mi_buf[k] = '0;
    tx_data = so_buf[0];
    spi_cs  = 1'b0;
    half();
    for (int i = 0; i < total; i++) begin
      int k;
      int b;
      k = i / 8;
      b = 7 - (i % 8);
      spi_mosi = mo_buf[k][b];
      half();
      mi_buf[k][b] = spi_miso;
      spi_sck = 1'b1;
      if (b == 4 && k + 1 < n) tx_data = so_buf[k+1];
      if (i == total - 1) begin
        last_lat = -1;
        for (int j = 1; j <= 4; j++) begin
          tick();
          if (last_lat < 0 && rx_valid) last_lat = j;
        end
      end else begin
        half();
      end
      spi_sck = 1'b0;
    end
    half();
    busy_mid = busy;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    half();
    half();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    cmp_cnt++;
    if ({rx_data, rx_valid, overrun, frame_err, busy, spi_miso} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rx_data=%h v=%b ovr=%b fe=%b busy=%b miso=%b, want all 0",
               rx_data, rx_valid, overrun, frame_err, busy, spi_miso);
    end
    rst_n = 1'b1;
    repeat (8) tick();
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_byte();
    int fe0;
    fe0 = fe_cnt;
    rx_ready  = 1'b0;
    mo_buf[0] = 8'hA5;
    so_buf[0] = 8'h00;
    spi_frame(1, 0);
    cmp_cnt++;
    if (last_lat < 1 || last_lat > 5) begin
      err_cnt++;
      $display("FAIL single_latency: got %0d clk want 1..5", last_lat);
    end
    cmp_cnt++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_data: got %h valid=%b want a5 valid=1", rx_data, rx_valid);
    end
    cmp_cnt++;
    if (fe_cnt - fe0 !== 0) begin
      err_cnt++;
      $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0);
    end
    cmp_cnt++;
    if (busy_mid !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_busy: got mid=%b after=%b want 1 then 0", busy_mid, busy);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    cmp_cnt++;
    if (rx_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_drain: got valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_miso();
    got_q.delete();
    rx_ready  = 1'b1;
    mo_buf[0] = 8'h00;
    so_buf[0] = 8'h3C;
    spi_frame(1, 0);
    cmp_cnt++;
    if (mi_buf[0] !== 8'h3C) begin
      err_cnt++;
      $display("FAIL miso_byte: got %h want 3c", mi_buf[0]);
    end
    cmp_cnt++;
    if (spi_miso !== 1'b0) begin
      err_cnt++;
      $display("FAIL miso_idle: got %b want 0", spi_miso);
    end
    cmp_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 8'h00) begin
      err_cnt++;
      $display("FAIL miso_rx: got %0d words want one 00", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    got_q.delete();
    rx_ready = 1'b1;
    exp_q = '{8'h12, 8'h34, 8'h56};
    for (int k = 0; k < 3; k++) begin
      mo_buf[k] = exp_q[k];
      so_buf[k] = 8'(k);
    end
    spi_frame(3, 0);
    cmp_cnt++;
    if (got_q.size() != 3) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d want 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        cmp_cnt++;
        if (got_q[k] !== exp_q[k]) begin
          err_cnt++;
          $display("FAIL b2b_word%0d: got %h want %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    cmp_cnt++;
    if (overrun !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    rx_ready  = 1'b0;
    so_buf[0] = 8'h00;
    mo_buf[0] = 8'h11;
    spi_frame(1, 0);
    mo_buf[0] = 8'h22;
    spi_frame(1, 0);
    cmp_cnt++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1 || overrun !== 1'b1) begin
      err_cnt++;
      $display("FAIL overrun_set: got %h v=%b ovr=%b want 11 v=1 ovr=1", rx_data, rx_valid, overrun);
    end
    rx_ready    = 1'b1;
    overrun_clr = 1'b1;
    tick();
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    tick();
    cmp_cnt++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      err_cnt++;
      $display("FAIL overrun_clear: got v=%b ovr=%b want 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_abort();
    int fe0;
    got_q.delete();
    fe0       = fe_cnt;
    rx_ready  = 1'b1;
    mo_buf[0] = 8'hFF;
    so_buf[0] = 8'h00;
    spi_frame(1, 5);
    cmp_cnt++;
    if (fe_cnt - fe0 !== 1) begin
      err_cnt++;
      $display("FAIL abort_pulse: got %0d clk want 1", fe_cnt - fe0);
    end
    cmp_cnt++;
    if (got_q.size() != 0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_no_word: got %0d words v=%b busy=%b want 0 0 0",
               got_q.size(), rx_valid, busy);
    end
    mo_buf[0] = 8'h7E;
    spi_frame(1, 0);
    cmp_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin
      err_cnt++;
      $display("FAIL abort_recover: got %0d words want one 7e", got_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    got_q.delete();
    rx_ready = 1'b1;
    tx_data  = 8'hFF;
    spi_cs   = 1'b0;
    half();
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      half();
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
    spi_sck = 1'b1;
    rst_n   = 1'b0;
    #1;
    cmp_cnt++;
    if ({rx_data, rx_valid, overrun, frame_err, busy, spi_miso} !== 13'd0) begin
      err_cnt++;
      $display("FAIL rst_mid_outputs: got rx_data=%h v=%b ovr=%b fe=%b busy=%b miso=%b, want 0",
               rx_data, rx_valid, overrun, frame_err, busy, spi_miso);
    end
    spi_sck = 1'b0;
    tick();
    tick();
    fe0   = fe_cnt;
    rst_n = 1'b1;
    repeat (10) tick();
    cmp_cnt++;
    if (busy !== 1'b0 || fe_cnt != fe0) begin
      err_cnt++;
      $display("FAIL rst_cs_low_release: got busy=%b fe=%0d want 0 0", busy, fe_cnt - fe0);
    end
    spi_cs = 1'b1;
    half();
    mo_buf[0] = 8'hC3;
    so_buf[0] = 8'h00;
    spi_frame(1, 0);
    cmp_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
      err_cnt++;
      $display("FAIL rst_recover: got %0d words want one c3", got_q.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 4);
      got_q.delete();
      rx_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
        mo_buf[k] = 8'($urandom);
        so_buf[k] = 8'($urandom);
      end
      spi_frame(n, 0);
      cmp_cnt++;
      if (got_q.size() != n) begin
        err_cnt++;
        $display("FAIL rand%0d_count: got %0d want %0d", f, got_q.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          cmp_cnt++;
          if (got_q[k] !== mo_buf[k]) begin
            err_cnt++;
            $display("FAIL rand%0d_rx%0d: got %h want %h", f, k, got_q[k], mo_buf[k]);
          end
        end
      end
      for (int k = 0; k < n; k++) begin
        cmp_cnt++;
        if (mi_buf[k] !== so_buf[k]) begin
          err_cnt++;
          $display("FAIL rand%0d_miso%0d: got %h want %h", f, k, mi_buf[k], so_buf[k]);
        end
      end
    end
  endtask

  initial begin
    spi_sck     = 1'b0;
    spi_mosi    = 1'b0;
    spi_cs      = 1'b1;
    tx_data     = 8'h00;
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    test_reset();
    test_single_byte();
    test_miso();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
